// File: rtl/word_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | word_pkg: shared state encoding and width helper for word_assembler |
// | Revision: 1.0                                                       |
// +------------------------------------------------------------------+
package word_pkg;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  // Ceiling log2, usable in constant expressions on tools lacking $clog2.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | word_assembler: packs CHUNK-bit stream chunks LSB-first into a   |
// | WIDTH-bit registered word, with zero-padded early flush.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module word_assembler
  import word_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [CHUNK-1:0]                       in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   flush,
  output logic [WIDTH-1:0]                       out_data,
  output logic [word_pkg::clog2(WIDTH/CHUNK+1)-1:0] out_count,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = clog2(NCHUNK + 1);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
  localparam logic [CW-1:0] FULL = CW'(NCHUNK);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("word_assembler: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  logic             state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             accept;

  assign in_ready  = rst_n && ((state_q == ST_FILL) || out_ready);
  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_valid = valid_q;

  always_comb begin
    accept  = in_valid && in_ready;
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;

    if (state_q == ST_FILL) begin
      if (accept) begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (cnt_q == CW'(i)) data_d[i*CHUNK +: CHUNK] = in_data;
        end
      end
      if (accept && (cnt_q == LAST)) begin
        state_d = ST_HOLD;
        valid_d = 1'b1;
        count_d = FULL;
        cnt_d   = '0;
      end else if (flush && (accept || (cnt_q != '0))) begin
        // A chunk arriving with the flush is included before emission.
        state_d = ST_HOLD;
        valid_d = 1'b1;
        count_d = cnt_q + CW'(accept);
        cnt_d   = '0;
      end else if (accept) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (out_ready) begin
      data_d  = '0;
      count_d = '0;
      valid_d = 1'b0;
      state_d = ST_FILL;
      cnt_d   = '0;
      if (accept) begin
        data_d[CHUNK-1:0] = in_data;
        if (NCHUNK == 1) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
          count_d = FULL;
        end else begin
          cnt_d = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

endmodule
`default_nettype wire
